// File: rtl/cnn_layer_accel_result_packer_if.sv
// Handshake and status bundle between the quad result port, the packer and the output writer.
interface cnn_layer_accel_result_packer_if #(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_PACK_FACTOR  = 8,
  parameter int unsigned C_OUT_WIDTH    = 128,
  parameter int unsigned C_DIM_WIDTH    = 10,
  parameter int unsigned C_DEPTH_WIDTH  = 7
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [C_DIM_WIDTH-1:0]    cfg_num_output_rows;
  logic [C_DIM_WIDTH-1:0]    cfg_num_output_cols;
  logic [C_DEPTH_WIDTH-1:0]  cfg_num_kernel;
  logic                      cfg_error;

  logic                      result_valid;
  logic                      result_accept;
  logic [C_RESULT_WIDTH-1:0] result_data;

  logic                      out_valid;
  logic                      out_ready;
  logic [C_OUT_WIDTH-1:0]    out_data;
  logic [C_PACK_FACTOR-1:0]  out_keep;
  logic                      out_last;

  logic [C_DIM_WIDTH-1:0]    output_row;
  logic [C_DIM_WIDTH-1:0]    output_col;
  logic [C_DEPTH_WIDTH-1:0]  output_depth;
  logic                      job_done;

  // Producer/consumer side: drives configuration, results and out_ready.
  modport master (
    output cfg_valid, cfg_num_output_rows, cfg_num_output_cols, cfg_num_kernel,
    output result_valid, result_data, out_ready,
    input  cfg_ready, cfg_error, result_accept,
    input  out_valid, out_data, out_keep, out_last,
    input  output_row, output_col, output_depth, job_done
  );

  // Packer side.
  modport slave (
    input  cfg_valid, cfg_num_output_rows, cfg_num_output_cols, cfg_num_kernel,
    input  result_valid, result_data, out_ready,
    output cfg_ready, cfg_error, result_accept,
    output out_valid, out_data, out_keep, out_last,
    output output_row, output_col, output_depth, job_done
  );
endinterface

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs quad results into wide output words with lane-keep and end-of-job marker,
// tracking the row/col/depth of the next result and buffering words in a small shift FIFO.
module cnn_layer_accel_result_packer #(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_PACK_FACTOR  = 8,
  parameter int unsigned C_OUT_WIDTH    = 128,
  parameter int unsigned C_FIFO_DEPTH   = 2,
  parameter int unsigned C_DIM_WIDTH    = 10,
  parameter int unsigned C_DEPTH_WIDTH  = 7
) (
  input logic clk_core,
  input logic rst,
  cnn_layer_accel_result_packer_if.slave bus
);

  localparam int unsigned LANE_W = (C_PACK_FACTOR > 1) ? $clog2(C_PACK_FACTOR) : 1;
  localparam int unsigned CNT_W  = $clog2(C_FIFO_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(C_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef logic [C_PACK_FACTOR-1:0][C_RESULT_WIDTH-1:0] lanes_t;

  typedef struct packed {
    lanes_t                   data;
    logic [C_PACK_FACTOR-1:0] keep;
    logic                     last;
  } word_t;

  state_e                   state_q, state_d;
  logic [C_DIM_WIDTH-1:0]   rows_q, rows_d;
  logic [C_DIM_WIDTH-1:0]   cols_q, cols_d;
  logic [C_DEPTH_WIDTH-1:0] kern_q, kern_d;
  logic [C_DIM_WIDTH-1:0]   row_q, row_d;
  logic [C_DIM_WIDTH-1:0]   col_q, col_d;
  logic [C_DEPTH_WIDTH-1:0] dep_q, dep_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  lanes_t                   pack_q, pack_d;
  logic [C_PACK_FACTOR-1:0] keep_q, keep_d;
  word_t                    fifo_q [C_FIFO_DEPTH];
  word_t                    fifo_d [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0]  vld_q, vld_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     accept_q, accept_d;
  logic                     cfg_error_q, cfg_error_d;
  logic                     job_done_q, job_done_d;

  logic                     accept_fire;
  logic                     pop;
  logic                     last_beat;
  logic                     push;
  lanes_t                   word_data;
  logic [C_PACK_FACTOR-1:0] word_keep;
  word_t                    new_word;
  logic [IDX_W-1:0]         wr_idx;

  // Beat decode and the word that would be pushed if this beat completes one.
  always_comb begin
    accept_fire = bus.result_valid & accept_q;
    pop         = vld_q[0] & bus.out_ready;
    last_beat   = accept_fire
                & (row_q == rows_q - C_DIM_WIDTH'(1))
                & (col_q == cols_q - C_DIM_WIDTH'(1))
                & (dep_q == kern_q - C_DEPTH_WIDTH'(1));
    push        = accept_fire & ((lane_q == LANE_W'(C_PACK_FACTOR - 1)) | last_beat);

    word_data            = pack_q;
    word_data[lane_q]    = bus.result_data;
    word_keep            = keep_q;
    word_keep[lane_q]    = 1'b1;
    new_word.data        = word_data;
    new_word.keep        = word_keep;
    new_word.last        = last_beat;
  end

  // Next-state: FSM, coordinate counters, lane packing and FIFO.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    kern_d      = kern_q;
    row_d       = row_q;
    col_d       = col_q;
    dep_d       = dep_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    keep_d      = keep_q;
    fifo_d      = fifo_q;
    vld_d       = vld_q;
    cnt_d       = cnt_q;
    cfg_error_d = 1'b0;
    job_done_d  = 1'b0;
    wr_idx      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid) begin
          if ((bus.cfg_num_output_rows == '0) || (bus.cfg_num_output_cols == '0) ||
              (bus.cfg_num_kernel == '0)) begin
            cfg_error_d = 1'b1;
          end else begin
            rows_d  = bus.cfg_num_output_rows;
            cols_d  = bus.cfg_num_output_cols;
            kern_d  = bus.cfg_num_kernel;
            row_d   = '0;
            col_d   = '0;
            dep_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          job_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Depth fastest, then col, then row; the final beat wraps all three to zero.
    if (accept_fire) begin
      if (dep_q == kern_q - C_DEPTH_WIDTH'(1)) begin
        dep_d = '0;
        if (col_q == cols_q - C_DIM_WIDTH'(1)) begin
          col_d = '0;
          row_d = (row_q == rows_q - C_DIM_WIDTH'(1)) ? '0 : row_q + C_DIM_WIDTH'(1);
        end else begin
          col_d = col_q + C_DIM_WIDTH'(1);
        end
      end else begin
        dep_d = dep_q + C_DEPTH_WIDTH'(1);
      end

      if (push) begin
        pack_d = '0;
        keep_d = '0;
        lane_d = '0;
      end else begin
        pack_d = word_data;
        keep_d = word_keep;
        lane_d = lane_q + LANE_W'(1);
      end
    end

    // Entry 0 is the output register; a pop shifts everything down one slot.
    if (pop) begin
      for (int unsigned i = 0; i + 1 < C_FIFO_DEPTH; i++) begin
        fifo_d[IDX_W'(i)] = fifo_q[IDX_W'(i + 1)];
        vld_d[IDX_W'(i)]  = vld_q[IDX_W'(i + 1)];
      end
      fifo_d[IDX_W'(C_FIFO_DEPTH - 1)] = '0;
      vld_d[IDX_W'(C_FIFO_DEPTH - 1)]  = 1'b0;
    end

    if (push) begin
      wr_idx         = pop ? IDX_W'(cnt_q - CNT_W'(1)) : IDX_W'(cnt_q);
      fifo_d[wr_idx] = new_word;
      vld_d[wr_idx]  = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    cfg_ready_d = (state_d == S_IDLE);
    accept_d    = (state_d == S_RUN) && (cnt_d < CNT_W'(C_FIFO_DEPTH));
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      kern_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      dep_q       <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      keep_q      <= '0;
      for (int unsigned i = 0; i < C_FIFO_DEPTH; i++) begin
        fifo_q[IDX_W'(i)] <= '0;
      end
      vld_q       <= '0;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b1;
      accept_q    <= 1'b0;
      cfg_error_q <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      kern_q      <= kern_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dep_q       <= dep_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      keep_q      <= keep_d;
      fifo_q      <= fifo_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      accept_q    <= accept_d;
      cfg_error_q <= cfg_error_d;
      job_done_q  <= job_done_d;
    end
  end

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.cfg_error     = cfg_error_q;
  assign bus.result_accept = accept_q;
  assign bus.out_valid     = vld_q[0];
  assign bus.out_data      = fifo_q[0].data;
  assign bus.out_keep      = fifo_q[0].keep;
  assign bus.out_last      = fifo_q[0].last;
  assign bus.output_row    = row_q;
  assign bus.output_col    = col_q;
  assign bus.output_depth  = dep_q;
  assign bus.job_done      = job_done_q;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed bench for the result packer: table of jobs with hand-computed final words,
// plus hand-written config-error and mid-job reset sequences.
module tb_cnn_layer_accel_result_packer;

  localparam int unsigned RW = 16;
  localparam int unsigned PF = 8;
  localparam int unsigned OW = 128;
  localparam int unsigned FD = 2;
  localparam int unsigned DW = 10;
  localparam int unsigned KW = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnn_layer_accel_result_packer_if #(
    .C_RESULT_WIDTH(RW), .C_PACK_FACTOR(PF), .C_OUT_WIDTH(OW),
    .C_DIM_WIDTH(DW), .C_DEPTH_WIDTH(KW)
  ) bus ();

  cnn_layer_accel_result_packer #(
    .C_RESULT_WIDTH(RW), .C_PACK_FACTOR(PF), .C_OUT_WIDTH(OW),
    .C_FIFO_DEPTH(FD), .C_DIM_WIDTH(DW), .C_DEPTH_WIDTH(KW)
  ) dut (
    .clk_core(clk),
    .rst     (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int           rows;
    int           cols;
    int           kern;
    logic [15:0]  base;
    bit           toggle;
    int           stall;
    int           exp_stall_sent;
    int           exp_words;
    logic [7:0]   exp_last_keep;
    logic [127:0] exp_last_data;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/cfg_ready"},     128'(bus.cfg_ready), 128'd1);
    chk({tag, "/cfg_error"},     128'(bus.cfg_error), 128'd0);
    chk({tag, "/result_accept"}, 128'(bus.result_accept), 128'd0);
    chk({tag, "/out_valid"},     128'(bus.out_valid), 128'd0);
    chk({tag, "/out_data"},      bus.out_data, 128'd0);
    chk({tag, "/keep_last"},     128'({bus.out_keep, bus.out_last}), 128'd0);
    chk({tag, "/coords"},        128'({bus.output_row, bus.output_col, bus.output_depth}), 128'd0);
    chk({tag, "/job_done"},      128'(bus.job_done), 128'd0);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int           total, sent, cyc, first_n;
    int           beat_cyc, first_valid_cyc, pop_cyc, done_cyc;
    bit           done, prev_stall;
    logic [127:0] held_d;
    logic [8:0]   held_kl;
    logic [127:0] wd[$];
    logic [7:0]   wk[$];
    logic         wl[$];
    logic [127:0] ed;
    logic [7:0]   ek;
    logic [26:0]  ecoord;
    int           idx, nchk;

    total   = v.rows * v.cols * v.kern;
    first_n = (total < 8) ? total : 8;
    sent = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0;
    beat_cyc = -1; first_valid_cyc = -1; pop_cyc = -1; done_cyc = -1;
    held_d = '0; held_kl = '0;

    chk({tag, "/cfg_ready_before"}, 128'(bus.cfg_ready), 128'd1);
    bus.cfg_num_output_rows = DW'(v.rows);
    bus.cfg_num_output_cols = DW'(v.cols);
    bus.cfg_num_kernel      = KW'(v.kern);
    bus.cfg_valid           = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    chk({tag, "/cfg_ready_run"}, 128'(bus.cfg_ready), 128'd0);

    while (!done && cyc < 4000) begin
      if (bus.job_done) begin
        done     = 1'b1;
        done_cyc = cyc;
      end else begin
        bus.result_valid = (sent < total);
        bus.result_data  = v.base + 16'(sent);
        if (cyc < v.stall)  bus.out_ready = 1'b0;
        else if (v.toggle)  bus.out_ready = cyc[0];
        else                bus.out_ready = 1'b1;

        if (v.stall > 0 && cyc == v.stall) begin
          chk({tag, "/sent_when_full"}, 128'(sent), 128'(v.exp_stall_sent));
          chk({tag, "/accept_when_full"}, 128'(bus.result_accept), 128'd0);
        end
        if (prev_stall) begin
          chk({tag, "/stall_data_stable"}, bus.out_data, held_d);
          chk({tag, "/stall_ctrl_stable"}, 128'({bus.out_valid, bus.out_keep, bus.out_last}),
              128'({1'b1, held_kl}));
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        if (bus.result_valid && bus.result_accept) begin
          ecoord = {DW'(sent / (v.kern * v.cols)), DW'((sent / v.kern) % v.cols),
                    KW'(sent % v.kern)};
          chk({tag, "/coords"}, 128'({bus.output_row, bus.output_col, bus.output_depth}),
              128'(ecoord));
          sent++;
          if (sent == first_n) beat_cyc = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
          wd.push_back(bus.out_data);
          wk.push_back(bus.out_keep);
          wl.push_back(bus.out_last);
          pop_cyc = cyc;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        held_d     = bus.out_data;
        held_kl    = {bus.out_keep, bus.out_last};
        step();
        cyc++;
      end
    end

    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/timeout: job_done not seen after %0d cycles, sent %0d of %0d",
               tag, cyc, sent, total);
    end else begin
      chk({tag, "/done_cfg_ready"}, 128'(bus.cfg_ready), 128'd1);
      chk({tag, "/done_coords"}, 128'({bus.output_row, bus.output_col, bus.output_depth}),
          128'd0);
      chk({tag, "/done_after_pop"}, 128'(done_cyc), 128'(pop_cyc + 2));
    end
    chk({tag, "/first_word_latency"}, 128'(first_valid_cyc), 128'(beat_cyc + 1));
    chk({tag, "/num_words"}, 128'(wd.size()), 128'(v.exp_words));

    nchk = (wd.size() < v.exp_words) ? wd.size() : v.exp_words;
    for (int w = 0; w < nchk; w++) begin
      ed = '0;
      ek = '0;
      for (int l = 0; l < 8; l++) begin
        idx = w * 8 + l;
        if (idx < total) begin
          ed[l*16 +: 16] = v.base + 16'(idx);
          ek[l]          = 1'b1;
        end
      end
      chk($sformatf("%s/word%0d_data", tag, w), wd[w], ed);
      chk($sformatf("%s/word%0d_keep", tag, w), 128'(wk[w]), 128'(ek));
      chk($sformatf("%s/word%0d_last", tag, w), 128'(wl[w]), 128'(w == v.exp_words - 1));
    end
    if (wd.size() > 0) begin
      chk({tag, "/final_data"}, wd[wd.size()-1], v.exp_last_data);
      chk({tag, "/final_keep"}, 128'(wk[wk.size()-1]), 128'(v.exp_last_keep));
    end

    bus.result_valid = 1'b0;
    bus.out_ready    = 1'b0;
    step();
    chk({tag, "/job_done_pulse"}, 128'(bus.job_done), 128'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent5, cyc5;
    vec_t post;

    tbl[0] = '{rows:1, cols:2, kern:4, base:16'h0001, toggle:1'b0, stall:0, exp_stall_sent:0,
               exp_words:1, exp_last_keep:8'hFF,
               exp_last_data:128'h0008_0007_0006_0005_0004_0003_0002_0001};
    tbl[1] = '{rows:1, cols:1, kern:3, base:16'h000A, toggle:1'b0, stall:0, exp_stall_sent:0,
               exp_words:1, exp_last_keep:8'h07,
               exp_last_data:128'h0000_0000_0000_0000_0000_000C_000B_000A};
    tbl[2] = '{rows:2, cols:2, kern:8, base:16'h0300, toggle:1'b0, stall:40, exp_stall_sent:16,
               exp_words:4, exp_last_keep:8'hFF,
               exp_last_data:128'h031F_031E_031D_031C_031B_031A_0319_0318};
    tbl[3] = '{rows:1, cols:8, kern:8, base:16'h0100, toggle:1'b1, stall:0, exp_stall_sent:0,
               exp_words:8, exp_last_keep:8'hFF,
               exp_last_data:128'h013F_013E_013D_013C_013B_013A_0139_0138};
    tbl[4] = '{rows:3, cols:1, kern:5, base:16'h0020, toggle:1'b1, stall:0, exp_stall_sent:0,
               exp_words:2, exp_last_keep:8'h7F,
               exp_last_data:128'h0000_002E_002D_002C_002B_002A_0029_0028};
    tbl[5] = '{rows:2, cols:3, kern:2, base:16'h0050, toggle:1'b0, stall:0, exp_stall_sent:0,
               exp_words:2, exp_last_keep:8'h0F,
               exp_last_data:128'h0000_0000_0000_0000_005B_005A_0059_0058};

    bus.cfg_valid           = 1'b0;
    bus.cfg_num_output_rows = '0;
    bus.cfg_num_output_cols = '0;
    bus.cfg_num_kernel      = '0;
    bus.result_valid        = 1'b0;
    bus.result_data         = '0;
    bus.out_ready           = 1'b0;

    step();
    step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 6; t++) begin
      run_job(tbl[t], $sformatf("job%0d", t));
    end

    // Zero column count must be rejected with a one-cycle error pulse.
    bus.cfg_num_output_rows = DW'(3);
    bus.cfg_num_output_cols = DW'(0);
    bus.cfg_num_kernel      = KW'(2);
    bus.cfg_valid           = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    chk("cfgerr/pulse",     128'(bus.cfg_error), 128'd1);
    chk("cfgerr/cfg_ready", 128'(bus.cfg_ready), 128'd1);
    chk("cfgerr/accept",    128'(bus.result_accept), 128'd0);
    step();
    chk("cfgerr/pulse_end", 128'(bus.cfg_error), 128'd0);
    chk("cfgerr/idle_ready", 128'(bus.cfg_ready), 128'd1);
    chk("cfgerr/idle_accept", 128'(bus.result_accept), 128'd0);

    // Mid-job asynchronous reset after 5 results.
    bus.cfg_num_output_rows = DW'(1);
    bus.cfg_num_output_cols = DW'(1);
    bus.cfg_num_kernel      = KW'(8);
    bus.cfg_valid           = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    bus.out_ready = 1'b1;
    sent5 = 0;
    cyc5  = 0;
    while (sent5 < 5 && cyc5 < 100) begin
      bus.result_valid = 1'b1;
      bus.result_data  = 16'h0040 + 16'(sent5);
      if (bus.result_accept) sent5++;
      step();
      cyc5++;
    end
    bus.result_valid = 1'b0;
    chk("midreset/sent", 128'(sent5), 128'd5);
    chk("midreset/no_word_before", 128'(bus.out_valid), 128'd0);
    chk("midreset/coords_before", 128'({bus.output_row, bus.output_col, bus.output_depth}),
        128'({10'd0, 10'd0, 7'd5}));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step();
    step();
    chk("midreset/held_no_word", 128'(bus.out_valid), 128'd0);
    rst_n = 1'b1;
    step();

    post = '{rows:1, cols:1, kern:8, base:16'h0060, toggle:1'b0, stall:0, exp_stall_sent:0,
             exp_words:1, exp_last_keep:8'hFF,
             exp_last_data:128'h0067_0066_0065_0064_0063_0062_0061_0060};
    run_job(post, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
